// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the mini-MIPS core.
//   Holds the PC, issues one instruction-memory request at a time over a
//   req/valid handshake, captures the returned instruction into IF/ID and
//   presents its opcode to the main control decoder. Hazard stalls hold IF/ID;
//   a taken branch from execute flushes IF/ID and redirects fetch.
//
// Ports
//   clk            in   rising-edge clock for all state
//   reset          in   synchronous, active-high
//   imem_req       out  one-cycle request pulse (registered)
//   imem_addr      out  request address, stable while a request is outstanding
//   imem_valid     in   response strobe, exactly once per request
//   imem_rdata     in   instruction data, used only with imem_valid
//   stall          in   hazard unit: IF/ID holds this cycle
//   branch_taken   in   execute stage: flush IF/ID, fetch from branch_target
//   branch_target  in   redirect address
//   if_id_instr    out  registered instruction
//   if_id_pc1      out  registered PC+1 of that instruction
//   if_id_valid    out  IF/ID holds a real instruction
//   op             out  opcode for the decoder, 4'b1111 (bubble) when invalid
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc1,
    output logic               if_id_valid,
    output logic [3:0]         op
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // present a request
        S_WAIT = 2'd1,   // request outstanding
        S_HOLD = 2'd2    // response buffered behind a stall
    } state_t;

    state_t             r_state, w_state_next;
    logic [PC_W-1:0]    r_pc, w_pc_next, w_pc1;
    logic [PC_W-1:0]    r_addr;
    logic               r_req;
    logic               r_discard, w_discard_next;
    logic [INSTR_W-1:0] r_buf_instr;
    logic [PC_W-1:0]    r_buf_pc1;
    logic [INSTR_W-1:0] r_if_id_instr;
    logic [PC_W-1:0]    r_if_id_pc1;
    logic               r_if_id_valid;
    logic               w_resp, w_keep;
    logic               w_load_mem, w_to_buf, w_load_buf;

    // PC arithmetic wraps modulo 2^PC_W by construction of the width.
    assign w_pc1  = r_pc + 1'b1;
    assign w_resp = (r_state == S_WAIT) && imem_valid;
    // A response is kept only if no redirect happened during its lifetime.
    assign w_keep = w_resp && !r_discard && !branch_taken;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_REQ;
        else       r_state <= w_state_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_discard_next = r_discard;
        case (r_state)
            S_REQ: begin
                // r_req is low only in the first cycle after reset; no request
                // goes out then, so stay and present it next cycle.
                if (r_req) begin
                    w_state_next = S_WAIT;
                    if (branch_taken) w_discard_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    w_discard_next = 1'b0;
                    if (!w_keep || !stall) w_state_next = S_REQ;
                    else                   w_state_next = S_HOLD;
                end else if (branch_taken) begin
                    w_discard_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken || !stall) w_state_next = S_REQ;
            end
            default: w_state_next = S_REQ;
        endcase
        if (branch_taken) w_pc_next = branch_target;
        else if (w_keep)  w_pc_next = w_pc1;
    end

    // ---------------- output / datapath-control decode ----------------
    always_comb begin
        w_load_mem = w_keep && !stall;
        w_to_buf   = w_keep && stall;
        w_load_buf = (r_state == S_HOLD) && !branch_taken && !stall;
        op         = r_if_id_valid ? r_if_id_instr[15:12] : 4'b1111;
    end

    // PC, request and discard registers. imem_req/imem_addr are registered
    // from the next state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_req     <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            r_discard <= w_discard_next;
            r_req     <= (w_state_next == S_REQ);
            // The address only moves when a new request is about to go out,
            // so it stays put for the whole of WAIT and HOLD.
            if (w_state_next == S_REQ) r_addr <= w_pc_next;
        end
    end

    // NOTE: the hold buffer has no reset; it is read only in HOLD, which is
    // entered only in the same edge that writes it.
    always_ff @(posedge clk) begin
        if (w_to_buf) begin
            r_buf_instr <= imem_rdata;
            r_buf_pc1   <= w_pc1;
        end
    end

    // IF/ID register: reset > branch flush > stall hold > load or bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_instr <= '0;
            r_if_id_pc1   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (w_load_mem) begin
                r_if_id_instr <= imem_rdata;
                r_if_id_pc1   <= w_pc1;
                r_if_id_valid <= 1'b1;
            end else if (w_load_buf) begin
                r_if_id_instr <= r_buf_instr;
                r_if_id_pc1   <= r_buf_pc1;
                r_if_id_valid <= 1'b1;
            end else begin
                r_if_id_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc1   = r_if_id_pc1;
    assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. A driver process models instruction
//   memory with random latency and applies random stalls and branches; each
//   response that should survive to IF/ID is pushed onto an expectation
//   queue, and any branch empties it. A separate monitor pops and compares
//   whenever IF/ID presents a new instruction.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int              PC_W     = 8;
    localparam int              INSTR_W  = 16;
    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc1;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               stall = 1'b0;
    logic               branch_taken = 1'b0;
    logic [PC_W-1:0]    branch_target = '0;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc1;
    logic               if_id_valid;
    logic [3:0]         op;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(PC_W), .RESET_PC(RESET_PC), .INSTR_W(INSTR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid),
        .op            (op)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents and stimulus knobs (written by main).
    logic [INSTR_W-1:0] mem [256];
    int lat_min = 1, lat_max = 1, stall_pct = 0, br_pct = 0;
    int trig_addr = -1;
    logic [PC_W-1:0] trig_tgt = '0;
    int rst_req = 0;

    // Reference model state (driver-owned; monitor pops exp_q).
    exp_t            exp_q[$];
    logic [PC_W-1:0] exp_pc = RESET_PC;
    bit              inf_busy = 1'b0;
    bit              inf_drop = 1'b0;
    logic [PC_W-1:0] inf_addr = '0;
    int              inf_wait = 0;
    int              req_cnt = 0;
    bit              post_rst = 1'b0;
    bit              prev_req = 1'b0;
    logic [PC_W-1:0] prev_req_addr = '0;

    // ---------------- driver: memory model + stall/branch stimulus ----------
    initial begin : driver
        bit              resp_now;
        bit              br;
        logic [PC_W-1:0] tgt;
        forever begin
            @(negedge clk);
            resp_now      = 1'b0;
            br            = 1'b0;
            tgt           = '0;
            imem_valid    = 1'b0;
            imem_rdata    = 16'($urandom);
            stall         = ($urandom_range(99) < stall_pct);
            branch_taken  = 1'b0;
            branch_target = 8'($urandom);
            if (rst_req > 0) begin
                reset = 1'b1;
                rst_req--;
                // A request cut off by reset still answers: stale data.
                if (inf_busy) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[inf_addr];
                    inf_busy   = 1'b0;
                end
                exp_q.delete();
                exp_pc   = RESET_PC;
                post_rst = 1'b1;
                prev_req = 1'b0;
            end else begin
                reset = 1'b0;
                if (post_rst) begin
                    // Stray response in the first cycle after reset.
                    post_rst   = 1'b0;
                    imem_valid = 1'b1;
                    imem_rdata = 16'hDEAD;
                end
                if (imem_req) begin
                    check("one_outstanding", 32'(inf_busy), 0);
                    check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
                    inf_busy = 1'b1;
                    inf_drop = 1'b0;
                    inf_addr = imem_addr;
                    inf_wait = $urandom_range(lat_max, lat_min);
                    req_cnt++;
                end else if (inf_busy) begin
                    check("addr_hold", 32'(imem_addr), 32'(inf_addr));
                    inf_wait--;
                    if (inf_wait == 0) begin
                        imem_valid = 1'b1;
                        imem_rdata = mem[inf_addr];
                        inf_busy   = 1'b0;
                        resp_now   = 1'b1;
                    end
                end
                if (prev_req && int'(prev_req_addr) == trig_addr) begin
                    br  = 1'b1;
                    tgt = trig_tgt;
                end else if ($urandom_range(99) < br_pct) begin
                    br  = 1'b1;
                    tgt = 8'($urandom);
                end
                if (br) begin
                    branch_taken  = 1'b1;
                    branch_target = tgt;
                    exp_q.delete();
                    inf_drop = 1'b1;
                    exp_pc   = tgt;
                end else if (resp_now && !inf_drop) begin
                    exp_q.push_back(exp_t'{instr: mem[inf_addr], pc1: inf_addr + 8'd1});
                    exp_pc = inf_addr + 8'd1;
                end
                prev_req      = imem_req;
                prev_req_addr = imem_addr;
            end
        end
    end

    // ---------------- monitor: IF/ID scoreboard ----------------
    initial begin : monitor
        bit   prev_v;
        exp_t last;
        exp_t e;
        prev_v = 1'b0;
        last   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("rst_imem_req", 32'(imem_req), 0);
                check("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
                check("rst_valid", 32'(if_id_valid), 0);
                check("rst_instr", 32'(if_id_instr), 0);
                check("rst_pc1", 32'(if_id_pc1), 0);
                check("rst_op", 32'(op), 32'hF);
                prev_v = 1'b0;
            end else begin
                if (branch_taken) begin
                    check("flush_valid", 32'(if_id_valid), 0);
                end else if (stall && prev_v) begin
                    check("hold_valid", 32'(if_id_valid), 1);
                    check("hold_instr", 32'(if_id_instr), 32'(last.instr));
                    check("hold_pc1", 32'(if_id_pc1), 32'(last.pc1));
                end else if (stall) begin
                    check("stall_bubble", 32'(if_id_valid), 0);
                end else if (if_id_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_instr: got 0x%0h pc1 0x%0h expected none at %0t",
                                 if_id_instr, if_id_pc1, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", 32'(if_id_instr), 32'(e.instr));
                        check("pc1", 32'(if_id_pc1), 32'(e.pc1));
                        check("op", 32'(op), 32'(e.instr[15:12]));
                        last = e;
                    end
                end
                if (!if_id_valid) check("bubble_op", 32'(op), 32'hF);
                prev_v = if_id_valid;
            end
        end
    end

    // ---------------- main: phase sequencing ----------------
    initial begin : main
        int c0;
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'h8001;
        mem[2] = 16'h5002;
        mem[5] = 16'h7FFF;
        rst_req = 3;

        // Latency 1, no hazards: one request every 2 cycles.
        repeat (12) @(posedge clk);
        c0 = req_cnt;
        repeat (20) @(posedge clk);
        check("tput_lat1", 32'(req_cnt - c0), 10);

        // Latency 3: one request every 4 cycles.
        lat_min = 3; lat_max = 3;
        repeat (10) @(posedge clk);
        c0 = req_cnt;
        repeat (20) @(posedge clk);
        check("tput_lat3", 32'(req_cnt - c0), 5);

        // Permanent stall: the response parks in HOLD, no further requests.
        lat_min = 1; lat_max = 1; stall_pct = 100;
        repeat (8) @(posedge clk);
        c0 = req_cnt;
        repeat (10) @(posedge clk);
        check("no_req_in_hold", 32'(req_cnt - c0), 0);
        stall_pct = 0;
        repeat (10) @(posedge clk);

        // Branch to 0x40 one cycle after the request at 5; 0x7FFF must be dropped.
        lat_min = 3; lat_max = 3; trig_addr = 5; trig_tgt = 8'h40;
        rst_req = 2;
        repeat (60) @(posedge clk);

        // Branch to 0xFF, with a coincident response and random stalls: PC wraps.
        lat_min = 1; lat_max = 1; trig_addr = 3; trig_tgt = 8'hFF; stall_pct = 40;
        rst_req = 2;
        repeat (60) @(posedge clk);
        trig_addr = -1; stall_pct = 0;

        // Reset while a request is outstanding; stale data must not land.
        lat_min = 3; lat_max = 3;
        repeat (6) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            if (inf_busy && !imem_req) found = 1'b1;
        end
        check("reached_wait", 32'(found), 1);
        rst_req = 2;
        repeat (30) @(posedge clk);

        // Random mixes of latency, stalls and branches.
        lat_min = 1; lat_max = 4; stall_pct = 30; br_pct = 8;
        repeat (600) @(posedge clk);
        stall_pct = 60; br_pct = 20;
        repeat (400) @(posedge clk);

        // Drain: everything expected must have been delivered.
        lat_min = 1; lat_max = 1; stall_pct = 0; br_pct = 0;
        repeat (30) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
